// File: rtl/avalon_host_pkg.sv
// Shared widths and FSM state type for the Avalon-MM host.
package avalon_host_pkg;

    localparam int unsigned ADDR_WIDTH = 2;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/avalon_host_if.sv
// Command/response handshake, Avalon-MM bus and irq signals of the host.
interface avalon_host_if;
    import avalon_host_pkg::*;

    logic                  cmdValid;
    logic                  cmdReady;
    logic                  cmdWrite;
    logic [ADDR_WIDTH-1:0] cmdAddress;
    logic [DATA_WIDTH-1:0] cmdData;
    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspData;
    logic                  rspError;
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  readValid;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  irq;
    logic                  irqPending;
    logic                  irqClear;

    modport master (
        input  cmdValid, cmdWrite, cmdAddress, cmdData, rspReady,
               readValid, dataIn, irq, irqClear,
        output cmdReady, rspValid, rspData, rspError, read, write,
               address, dataOut, irqPending
    );

    modport slave (
        output cmdValid, cmdWrite, cmdAddress, cmdData, rspReady,
               readValid, dataIn, irq, irqClear,
        input  cmdReady, rspValid, rspData, rspError, read, write,
               address, dataOut, irqPending
    );

endinterface

// File: rtl/avalon_host_irq_latch.sv
// Rising-edge detector on the responder irq feeding a sticky pending flag.
module irq_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic irqClear,
    output logic irqPending
);

    logic r_irq_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise = irq & ~r_irq_prev;

    // A new edge beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_irq_prev <= irq;
            r_pending  <= w_rise | (r_pending & ~irqClear);
        end
    end

    assign irqPending = r_pending;

endmodule

// File: rtl/avalon_host.sv
// Avalon-MM initiator: single-beat reads/writes from a cmd/rsp handshake,
// read timeout on readValid, and a sticky irq flag.
module avalon_host
    import avalon_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic            clk,
    input logic            reset,
    avalon_host_if.master  bus
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next, w_cnt_inc;
    logic                  w_timeout;
    logic                  r_read, w_read;
    logic                  r_write, w_write;
    logic [ADDR_WIDTH-1:0] r_address, w_address;
    logic [DATA_WIDTH-1:0] r_dataOut, w_dataOut;
    logic                  r_rspValid, w_rspValid;
    logic [DATA_WIDTH-1:0] r_rspData, w_rspData;
    logic                  r_rspError, w_rspError;

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_address  <= '0;
            r_dataOut  <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspError <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_read     <= w_read;
            r_write    <= w_write;
            r_address  <= w_address;
            r_dataOut  <= w_dataOut;
            r_rspValid <= w_rspValid;
            r_rspData  <= w_rspData;
            r_rspError <= w_rspError;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.cmdValid) w_state_next = bus.cmdWrite ? WRITE : READ;
            READ:    w_state_next = WAIT;
            WRITE:   w_state_next = RESP;
            WAIT:    if (bus.readValid || w_timeout) w_state_next = RESP;
            RESP:    if (bus.rspReady) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered outputs are loaded one state early so strobes line up with their state
    always_comb begin
        w_cnt_next = r_cnt;
        w_read     = 1'b0;
        w_write    = 1'b0;
        w_address  = r_address;
        w_dataOut  = r_dataOut;
        w_rspValid = r_rspValid;
        w_rspData  = r_rspData;
        w_rspError = r_rspError;
        case (r_state)
            IDLE: begin
                if (bus.cmdValid) begin
                    w_address = bus.cmdAddress;
                    w_dataOut = bus.cmdData;
                    w_read    = ~bus.cmdWrite;
                    w_write   = bus.cmdWrite;
                end
            end
            READ: w_cnt_next = '0;
            WRITE: begin
                w_rspValid = 1'b1;
                w_rspData  = '0;
                w_rspError = 1'b0;
            end
            WAIT: begin
                if (bus.readValid) begin
                    w_rspValid = 1'b1;
                    w_rspData  = bus.dataIn;
                    w_rspError = 1'b0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_timeout) begin
                        w_rspValid = 1'b1;
                        w_rspData  = '0;
                        w_rspError = 1'b1;
                    end
                end
            end
            RESP: if (bus.rspReady) w_rspValid = 1'b0;
            default: ;
        endcase
    end

    assign bus.cmdReady = (r_state == IDLE);
    assign bus.read     = r_read;
    assign bus.write    = r_write;
    assign bus.address  = r_address;
    assign bus.dataOut  = r_dataOut;
    assign bus.rspValid = r_rspValid;
    assign bus.rspData  = r_rspData;
    assign bus.rspError = r_rspError;

    irq_latch u_irq_latch (
        .clk        (clk),
        .reset      (reset),
        .irq        (bus.irq),
        .irqClear   (bus.irqClear),
        .irqPending (bus.irqPending)
    );

endmodule

// File: tb/tb_avalon_host.sv
// Randomized bench for avalon_host against a register-file responder and a
// transaction-level model of expected responses and latencies.
module tb_avalon_host;
    import avalon_host_pkg::*;

    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    avalon_host_if bus ();

    avalon_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder: readValid comes resp_lat cycles after the read strobe (0 = never)
    logic [31:0] resp_regs [4];
    int          resp_cnt = 0;
    int          resp_lat = 1;

    assign bus.readValid = (resp_cnt == 1);
    assign bus.dataIn    = resp_regs[bus.address];

    always @(posedge clk) begin
        if (bus.write) resp_regs[bus.address] <= bus.dataOut;
        if (bus.read) resp_cnt <= resp_lat;
        else if (resp_cnt > 0) resp_cnt <= resp_cnt - 1;
    end

    int          n_rd = 0;
    int          n_wr = 0;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;

    always @(negedge clk) begin
        if (bus.read) n_rd++;
        if (bus.write) begin
            n_wr++;
            wr_addr = bus.address;
            wr_data = bus.dataOut;
        end
    end

    logic [31:0] model_regs [4];

    // Called at a negedge; returns at a negedge after the response handshake
    task automatic run_cmd(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                           input int lat, input int hold);
        int          n;
        bit          ok;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] held;

        if (wr) begin
            exp_data = '0;
            exp_err  = 1'b0;
            exp_lat  = 2;
            model_regs[addr] = data;
        end else if (lat >= 1 && lat <= int'(TO)) begin
            exp_data = model_regs[addr];
            exp_err  = 1'b0;
            exp_lat  = 2 + lat;
        end else begin
            exp_data = '0;
            exp_err  = 1'b1;
            exp_lat  = int'(TO) + 2;
        end

        n = 0;
        while (!bus.cmdReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmdReady_idle", bus.cmdReady, 1);

        resp_lat = lat;
        n_rd = 0;
        n_wr = 0;
        bus.cmdValid   = 1'b1;
        bus.cmdWrite   = wr;
        bus.cmdAddress = addr;
        bus.cmdData    = data;
        @(posedge clk);
        @(negedge clk);
        bus.cmdValid   = 1'b0;
        bus.cmdWrite   = 1'($urandom);
        bus.cmdAddress = 2'($urandom);
        bus.cmdData    = $urandom;

        n  = 1;
        ok = 1'b1;
        while (!bus.rspValid && n < 40) begin
            if (bus.cmdReady || bus.address !== addr) ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("busy_addr_held", ok, 1);
        check("rsp_latency", n, exp_lat);
        check("rspData", bus.rspData, exp_data);
        check("rspError", bus.rspError, exp_err);
        if (wr) begin
            check("write_pulses", n_wr, 1);
            check("write_addr", wr_addr, addr);
            check("write_data", wr_data, data);
            check("write_no_read", n_rd, 0);
        end else begin
            check("read_pulses", n_rd, 1);
            check("read_no_write", n_wr, 0);
        end

        held = bus.rspData;
        ok   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rspValid || bus.rspData !== held || bus.cmdReady) ok = 1'b0;
        end
        if (hold > 0) check("rsp_held", ok, 1);

        bus.rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rspReady = 1'b0;
        check("rsp_done", {bus.rspValid, bus.cmdReady}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.cmdValid   = 1'b0;
        bus.cmdWrite   = 1'b0;
        bus.cmdAddress = '0;
        bus.cmdData    = '0;
        bus.rspReady   = 1'b0;
        bus.irq        = 1'b0;
        bus.irqClear   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp_regs[i]  = $urandom;
            model_regs[i] = resp_regs[i];
        end
        resp_regs[0]  = 32'h0000_03E8;
        model_regs[0] = 32'h0000_03E8;

        #1;
        check("rst_cmdReady", bus.cmdReady, 1);
        check("rst_rsp", {bus.rspValid, bus.rspError}, 2'b00);
        check("rst_rspData", bus.rspData, 0);
        check("rst_strobes", {bus.read, bus.write}, 2'b00);
        check("rst_address", bus.address, 0);
        check("rst_dataOut", bus.dataOut, 0);
        check("rst_irqPending", bus.irqPending, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(1'b1, 2'd1, 32'h3, 1, 0);
        run_cmd(1'b0, 2'd0, $urandom, 1, 0);
        run_cmd(1'b0, 2'd2, $urandom, 0, 0);
        run_cmd(1'b0, 2'd3, $urandom, 15, 0);
        run_cmd(1'b0, 2'd1, $urandom, 16, 0);
        run_cmd(1'b0, 2'd1, $urandom, 1, 10);

        bus.irq = 1'b0;
        @(negedge clk);
        check("irq_idle", bus.irqPending, 0);
        bus.irq      = 1'b1;
        bus.irqClear = 1'b1;
        @(negedge clk);
        bus.irqClear = 1'b0;
        check("irq_set_wins", bus.irqPending, 1);
        @(negedge clk);
        check("irq_sticky", bus.irqPending, 1);
        bus.irqClear = 1'b1;
        @(negedge clk);
        bus.irqClear = 1'b0;
        check("irq_cleared", bus.irqPending, 0);
        repeat (3) @(negedge clk);
        check("irq_level_no_reset", bus.irqPending, 0);
        bus.irq = 1'b0;
        @(negedge clk);
        bus.irq = 1'b1;
        @(negedge clk);
        check("irq_rearm", bus.irqPending, 1);

        resp_lat       = 0;
        bus.cmdValid   = 1'b1;
        bus.cmdWrite   = 1'b0;
        bus.cmdAddress = 2'd2;
        @(posedge clk);
        @(negedge clk);
        bus.cmdValid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_busy", bus.cmdReady, 0);
        #2;
        reset   = 1'b1;
        bus.irq = 1'b0;
        #1;
        check("arst_strobes", {bus.read, bus.write}, 2'b00);
        check("arst_rspValid", bus.rspValid, 0);
        check("arst_irqPending", bus.irqPending, 0);
        check("arst_cmdReady", bus.cmdReady, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_no_rsp", bus.rspValid, 0);
        run_cmd(1'b0, 2'd0, $urandom, 1, 0);

        for (int t = 0; t < 40; t++) begin
            int sel;
            int lat;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) lat = 0;
            else if (sel == 1) lat = 16;
            else lat = int'($urandom_range(1, 15));
            run_cmd(1'($urandom), 2'($urandom), $urandom, lat, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/avalon_host.md
# avalon_host

Avalon-MM initiator that drives the peripheral register bus from a simple command/response handshake. It issues single-beat reads and writes to a 2-bit-address, 32-bit-data responder and waits for the responder's registered read-valid. It also latches the responder's interrupt into a sticky pending flag. It sits between a sequencer or CPU-side bridge and any peripheral wrapper on this bus.

## Interface
- TIMEOUT_CYCLES, 15: cycles to wait for readValid after a read strobe before reporting an error (1..255).
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmdValid  input  1  command present.
- cmdReady  output  1  host can accept a command.
- cmdWrite  input  1  1 = write, 0 = read.
- cmdAddress  input  2  register address.
- cmdData  input  32  write data; ignored for reads.
- rspValid  output  1  response available; held until accepted.
- rspReady  input  1  consumer accepts response.
- rspData  output  32  read data; 0 for writes and errors.
- rspError  output  1  1 = read timed out.
- read  output  1  bus read strobe.
- write  output  1  bus write strobe.
- address  output  2  bus address.
- dataOut  output  32  bus write data, to the responder's dataIn.
- readValid  input  1  responder read-valid.
- dataIn  input  32  responder read data, from the responder's dataOut.
- irq  input  1  responder interrupt, level.
- irqPending  output  1  sticky irq-seen flag.
- irqClear  input  1  clears irqPending.

## Operation
- FSM states are IDLE, READ, WRITE, WAIT and RESP.
- IDLE:
  - cmdReady = 1.
  - On cmdValid: register cmdWrite, cmdAddress and cmdData, then go to WRITE (if cmdWrite) or READ.
- WRITE:
  - write = 1 for exactly one cycle, with address and dataOut driven.
  - Go to RESP with rspData = 0 and rspError = 0.
- READ:
  - read = 1 for exactly one cycle.
  - Clear the timeout counter and go to WAIT.
- WAIT:
  - read = 0. address is held stable, because responder read data is decoded combinationally from the address.
  - When readValid = 1: capture dataIn into rspData, set rspError = 0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES: rspData = 0, rspError = 1, go to RESP.
  - readValid arriving in the same cycle as the timeout is treated as success.
- RESP:
  - rspValid = 1 with rspData and rspError stable.
  - On rspReady: go to IDLE.
- readValid outside WAIT is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- irq latch:
  - A rising edge of irq (compared with the previous-cycle registered irq) sets irqPending.
  - irqClear clears irqPending.
  - If a set and a clear occur in the same cycle, the set wins.
  - A level held high does not re-set the flag after a clear.

## Timing
- Reset values:
  - state = IDLE, so cmdReady = 1.
  - rspValid = 0, rspData = 0, rspError = 0.
  - read = 0, write = 0, address = 0, dataOut = 0.
  - irqPending = 0; the previous-irq register = 0.
- All bus outputs and rsp* outputs are registered. cmdReady decodes state.
- Write: command accepted at edge 0, write = 1 in cycle 1, rspValid = 1 in cycle 2.
- Read against a 1-cycle responder: command accepted at edge 0, read = 1 in cycle 1, readValid = 1 in cycle 2, rspValid = 1 in cycle 3.
- Back-to-back throughput is one command per 3 cycles (write) or 4 cycles (read), with rspReady held high.
- A reset asserted mid-transaction aborts it immediately:
  - all outputs return to their reset values asynchronously;
  - no response is produced;
  - the command in flight is lost.

## Structure
- avalon_host_pkg holds:
  - the state enum (IDLE, READ, WRITE, WAIT, RESP);
  - ADDR_WIDTH = 2 and DATA_WIDTH = 32.
- Sub-module irq_latch (clk, reset, irq, irqClear, irqPending) contains the edge detector and the sticky flag.

## Test plan
- Write addr 1, data 0x3 → write = 1 for one cycle with address = 1 and dataOut = 0x3; rspValid two cycles after acceptance with rspData = 0 and rspError = 0.
- Read addr 0 against a responder model returning 0x000003E8 → read pulses one cycle, address is held through WAIT, and rspData = 0x000003E8 with rspError = 0 three cycles after acceptance.
- Read to a responder that never asserts readValid, TIMEOUT_CYCLES = 15 → rspError = 1 and rspData = 0 after 15 WAIT cycles; cmdReady is low throughout.
- rspReady held low for 10 cycles → rspValid and rspData stay stable and cmdReady stays 0; the next command is accepted only after the handshake.
- irq rises while irqClear pulses in the same cycle → irqPending = 1; a later irqClear with irq still high → irqPending = 0 and stays 0.
- Reset asserted during WAIT → read, write, rspValid and irqPending go to 0 immediately; after release the first read completes normally.
